cpu_ctrl: RTL and testbench

Eight-phase instruction-cycle controller for the 8-bit RISC core. It drives the program counter's load and increment enables, the memory read/write strobes, the address-mux select, the IR and accumulator load enables, and the data-bus driver enable. It takes its 3-bit opcode from the instruction register and the zero flag from the accumulator. It halts on HLT and resumes on an external `go` pulse. It also keeps a free-running count of retired instructions.

---
 rtl/cpu_ctrl.sv | 139 +++++++++++++
 tb/tb_cpu_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Eight-phase instruction-cycle controller: one instruction per 8 cycles, strobes decoded combinationally.
// HLT parks the sequencer in phase 3 until go; there is no other backpressure.
module cpu_ctrl #(
  parameter int ICNT_W = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [2:0]        opcode,
  input  logic              zero,
  input  logic              go,
  output logic              sel,
  output logic              rd,
  output logic              wr,
  output logic              ld_ir,
  output logic              ld_ac,
  output logic              inc_pc,
  output logic              ld_pc,
  output logic              data_e,
  output logic              halt,
  output logic [2:0]        phase,
  output logic [ICNT_W-1:0] icount
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Low three bits of the running states equal the phase number.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_DECODE     = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ICNT_W-1:0] r_icount;
  logic [2:0]        w_phase_inc;
  logic              w_aluop;
  logic              w_is_hlt;
  logic              w_is_skz;
  logic              w_is_sto;
  logic              w_is_jmp;

  assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_is_hlt = (opcode == OP_HLT);
  assign w_is_skz = (opcode == OP_SKZ);
  assign w_is_sto = (opcode == OP_STO);
  assign w_is_jmp = (opcode == OP_JMP);

  assign w_phase_inc = r_state[2:0] + 3'd1;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state  <= S_INST_ADDR;
      r_icount <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_STORE) begin
        r_icount <= r_icount + ICNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = state_t'({1'b0, w_phase_inc});
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (r_state)
      S_INST_ADDR: begin
        sel = 1'b1;
      end
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_DECODE: begin
        halt = w_is_hlt;
        if (w_is_hlt) begin
          w_next = S_HALTED;
        end
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
      end
      S_OP_FETCH: begin
        rd = w_aluop;
      end
      S_ALU_OP: begin
        rd     = w_aluop;
        inc_pc = w_is_skz & zero;
        ld_pc  = w_is_jmp;
        data_e = w_is_sto;
      end
      S_STORE: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        wr     = w_is_sto;
        data_e = w_is_sto;
      end
      S_HALTED: begin
        // Resume straight into OP_ADDR so the PC steps past the HLT word.
        halt   = 1'b1;
        w_next = go ? S_OP_ADDR : S_HALTED;
      end
      default: begin
        w_next = S_INST_ADDR;
      end
    endcase
  end

  assign phase  = (r_state == S_HALTED) ? 3'd3 : r_state[2:0];
  assign icount = r_icount;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed and random instruction streams against an abstract
// phase/halt/retire model, with async reset hits mid-store and while halted.
module tb_cpu_ctrl;

  localparam int ICNT_W = 8;

  logic              pclk;
  logic              rst;
  logic [2:0]        opcode;
  logic              zero;
  logic              go;
  logic              sel;
  logic              rd;
  logic              wr;
  logic              ld_ir;
  logic              ld_ac;
  logic              inc_pc;
  logic              ld_pc;
  logic              data_e;
  logic              halt;
  logic [2:0]        phase;
  logic [ICNT_W-1:0] icount;

  int n_chk = 0;
  int n_err = 0;

  int m_phase   = 0;
  bit m_halted  = 1'b0;
  int m_icount  = 0;

  cpu_ctrl #(.ICNT_W(ICNT_W)) dut (
    .pclk   (pclk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .go     (go),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase),
    .icount (icount)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobes {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt} from the phase table.
  function automatic logic [8:0] exp_out(int ph, bit hl, logic [2:0] op, logic z);
    logic alu, s, r, w, li, la, ip, lp, de, h;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    {s, r, w, li, la, ip, lp, de, h} = 9'd0;
    if (hl) h = 1'b1;
    else begin
      case (ph)
        0: s = 1'b1;
        1: begin s = 1'b1; r = 1'b1; end
        2: begin s = 1'b1; r = 1'b1; li = 1'b1; end
        3: h = (op == 3'd0);
        4: ip = 1'b1;
        5: r = alu;
        6: begin r = alu; ip = (op == 3'd1) && z; lp = (op == 3'd7); de = (op == 3'd6); end
        7: begin r = alu; la = alu; w = (op == 3'd6); de = (op == 3'd6); end
        default: ;
      endcase
    end
    return {s, r, w, li, la, ip, lp, de, h};
  endfunction

  task automatic model_step(input logic [2:0] op, input logic g);
    if (m_halted) begin
      if (g) begin
        m_halted = 1'b0;
        m_phase  = 4;
      end
    end else if (m_phase == 3 && op == 3'd0) begin
      m_halted = 1'b1;
    end else begin
      if (m_phase == 7) m_icount = (m_icount + 1) % (1 << ICNT_W);
      m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic check_now();
    chk("strobes", 32'({sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}),
        32'(exp_out(m_phase, m_halted, opcode, zero)));
    chk("phase", 32'(phase), m_phase);
    chk("icount", 32'(icount), m_icount);
    chk("inv_pc", 32'(ld_pc & inc_pc), 32'd0);
    chk("inv_rw", 32'(rd & wr), 32'd0);
    chk("inv_wr_de", 32'(wr & ~data_e), 32'd0);
  endtask

  // Starts and ends at a falling edge; outputs checked 1 time unit after inputs settle.
  task automatic cycle(input logic [2:0] op, input logic z, input logic g);
    opcode = op;
    zero   = z;
    go     = g;
    #1;
    check_now();
    @(posedge pclk);
    if (!rst) model_step(op, g);
    @(negedge pclk);
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input bit rand_go);
    int   guard;
    int   held;
    logic g;
    guard = 0;
    held  = 0;
    do begin
      g = rand_go ? 1'($urandom_range(0, 1)) : 1'b0;
      if (m_halted) begin
        held++;
        if (held > 6) g = 1'b1;
      end
      cycle(op, z, g);
      guard++;
    end while (m_phase != 0 && guard < 64);
    chk("instr_bound", 32'(m_phase), 32'd0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m_phase  = 0;
    m_halted = 1'b0;
    m_icount = 0;
    chk("rst_wr", 32'(wr), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd1);
    @(negedge pclk);
    cycle(opcode, zero, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int ic0;
    rst    = 1'b1;
    opcode = 3'd0;
    zero   = 1'b0;
    go     = 1'b0;

    // Reset held two cycles, then first LDA
    cycle(3'd5, 1'b0, 1'b0);
    cycle(3'd5, 1'b0, 1'b0);
    rst = 1'b0;
    run_instr(3'd5, 1'b0, 1'b0);
    chk("icount_first", 32'(icount), 32'd1);

    // STO, SKZ both ways, JMP
    run_instr(3'd6, 1'b0, 1'b0);
    run_instr(3'd1, 1'b1, 1'b0);
    run_instr(3'd1, 1'b0, 1'b0);
    run_instr(3'd7, 1'b1, 1'b0);

    // HLT with go on the entering edge (ignored), 10 halted cycles, then resume
    cycle(3'd0, 1'b0, 1'b0);
    cycle(3'd0, 1'b0, 1'b0);
    cycle(3'd0, 1'b0, 1'b0);
    #1 chk("hlt_rise", 32'(halt), 32'd1);
    cycle(3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(3'd0, 1'b0, 1'b0);
    #1;
    chk("hlt_hold_phase", 32'(phase), 32'd3);
    chk("hlt_hold_halt", 32'(halt), 32'd1);
    ic0 = m_icount;
    cycle(3'd0, 1'b0, 1'b1);
    #1;
    chk("go_phase", 32'(phase), 32'd4);
    chk("go_inc_pc", 32'(inc_pc), 32'd1);
    chk("go_halt", 32'(halt), 32'd0);
    for (int i = 0; i < 4; i++) cycle(3'd0, 1'b0, 1'b0);
    chk("hlt_retire", 32'(icount), 32'((ic0 + 1) % (1 << ICNT_W)));

    // Random stream, including HLT and stray go pulses
    for (int i = 0; i < 120; i++) begin
      run_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Reset during phase 7 of STO
    for (int i = 0; i < 7; i++) cycle(3'd6, 1'b0, 1'b0);
    #1 chk("sto_wr_pre", 32'(wr), 32'd1);
    async_reset();

    // Reset while halted
    for (int i = 0; i < 6; i++) cycle(3'd0, 1'b0, 1'b0);
    #1 chk("halted_pre", 32'(halt), 32'd1);
    async_reset();

    // 256 instructions from reset wrap icount to 0
    for (int i = 0; i < 256; i++) begin
      run_instr(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'b0);
    end
    #1 chk("icount_wrap", 32'(icount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
